// File: rtl/encoder42_seq.sv
// encoder42_seq: sequential 4-to-2 encoder with a valid/ready output.
// Latches request strobes into a pending register and issues one code at a time.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   en       capture enable for d
//   d[3:0]   request strobes, bit i requests code i
//   y[1:0]   encoded index, meaningful while valid=1
//   valid    y holds an unconsumed code
//   ready    consumer accepts y when valid=1 and ready=1
//   pending  requests latched and not yet issued
//   drop     one-cycle pulse, a request merged into an already-pending bit
//   busy     pending requests or a held code
// Build option: define ENCODER42_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority, highest index first (3 > 2 > 1 > 0).
module encoder42_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] d,
    output logic [1:0] y,
    output logic       valid,
    input  logic       ready,
    output logic [3:0] pending,
    output logic       drop,
    output logic       busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state;
    logic       load;
    logic [1:0] g;
    logic [3:0] gnt;
    logic [3:0] cap;

`ifdef ENCODER42_ROUND_ROBIN_EN
    logic [1:0] last;
    logic [1:0] idx;

    // Search from last+1 upward; scanning offsets 4..1 and letting later
    // hits overwrite means offset 1 wins and `last` itself comes last.
    always_comb begin
        g   = 2'd0;
        idx = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (pending[idx]) g = idx;
        end
    end
`else
    always_comb begin
        if (pending[3])      g = 2'd3;
        else if (pending[2]) g = 2'd2;
        else if (pending[1]) g = 2'd1;
        else                 g = 2'd0;
    end
`endif

    // The output register may take a new code when empty or being drained.
    assign load = (state == EMPTY) || ready;
    assign gnt  = (load && |pending) ? (4'b0001 << g) : 4'b0000;
    assign cap  = en ? d : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            y       <= 2'd0;
            pending <= 4'b0000;
            drop    <= 1'b0;
`ifdef ENCODER42_ROUND_ROBIN_EN
            last    <= 2'd3;
`endif
        end else begin
            // Set wins over clear: a bit re-requested in its grant cycle stays.
            pending <= (pending & ~gnt) | cap;
            drop    <= |(cap & pending & ~gnt);
            if (load) begin
                if (|pending) begin
                    state <= FULL;
                    y     <= g;
`ifdef ENCODER42_ROUND_ROBIN_EN
                    last  <= g;
`endif
                end else begin
                    state <= EMPTY;
                end
            end
        end
    end

    assign valid = (state == FULL);
    assign busy  = (|pending) | valid;

endmodule

// File: tb/tb_encoder42_seq.sv
// tb_encoder42_seq: directed bench for encoder42_seq.
// Expected codes are queued by the stimulus and checked by a handshake monitor.
module tb_encoder42_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] d = 4'b0000;
    logic       ready = 1'b0;
    logic [1:0] y;
    logic       valid;
    logic [3:0] pending;
    logic       drop;
    logic       busy;

    int tests = 0;
    int fails = 0;
    logic [1:0] q[$];

    encoder42_seq dut (
        .clk(clk), .rst(rst), .en(en), .d(d),
        .y(y), .valid(valid), .ready(ready),
        .pending(pending), .drop(drop), .busy(busy)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted code must match the head of the queue.
    always @(negedge clk) begin
        logic [1:0] e;
        if (!rst && valid && ready) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL extra_code: got y=%0d, none expected", y);
            end else begin
                e = q.pop_front();
                if (y !== e) begin
                    fails++;
                    $display("FAIL code_order: got y=%0d expected %0d", y, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        d = 4'b0000;
        ready = 1'b0;
        #1;
        rst = 1'b0;
        q.delete();
    endtask

    task automatic drain(string name);
        int n = 0;
        while ((q.size() != 0 || busy) && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (q.size() != 0 || busy) begin
            fails++;
            $display("FAIL %s_drain: left=%0d busy=%0d expected 0 0",
                     name, q.size(), busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, before any clock edge.
        #3;
        chk("rst_y", 8'(y), 8'h0);
        chk("rst_valid", 8'(valid), 8'h0);
        chk("rst_pending", 8'(pending), 8'h0);
        chk("rst_drop", 8'(drop), 8'h0);
        chk("rst_busy", 8'(busy), 8'h0);
        tick();
        rst = 1'b0;

        // Asynchronous reset mid-transfer with pending=1010 and valid=1.
        en = 1'b1;
        d = 4'b1000;
        tick();
        d = 4'b0000;
        tick();
        d = 4'b1010;
        tick();
        d = 4'b0000;
        chk("pre_rst_valid", 8'(valid), 8'h1);
        chk("pre_rst_pending", 8'(pending), 8'ha);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 8'(valid), 8'h0);
        chk("arst_pending", 8'(pending), 8'h0);
        chk("arst_busy", 8'(busy), 8'h0);
        chk("arst_y", 8'(y), 8'h0);
        tick();
        rst = 1'b0;
        ready = 1'b1;
        repeat (3) tick();
        chk("post_rst_valid", 8'(valid), 8'h0);
        chk("post_rst_busy", 8'(busy), 8'h0);

        // Single request: code 2 two cycles later, for one cycle.
        do_reset();
        en = 1'b1;
        ready = 1'b1;
        d = 4'b0100;
        q.push_back(2'd2);
        tick();
        d = 4'b0000;
        chk("single_lat1_valid", 8'(valid), 8'h0);
        chk("single_pending", 8'(pending), 8'h4);
        tick();
        chk("single_valid", 8'(valid), 8'h1);
        chk("single_y", 8'(y), 8'h2);
        tick();
        chk("single_done_valid", 8'(valid), 8'h0);
        chk("single_done_busy", 8'(busy), 8'h0);

        // Four simultaneous requests: four back-to-back codes.
        do_reset();
        en = 1'b1;
        ready = 1'b1;
        d = 4'b1111;
`ifdef ENCODER42_ROUND_ROBIN_EN
        q.push_back(2'd0); q.push_back(2'd1);
        q.push_back(2'd2); q.push_back(2'd3);
`else
        q.push_back(2'd3); q.push_back(2'd2);
        q.push_back(2'd1); q.push_back(2'd0);
`endif
        tick();
        d = 4'b0000;
        chk("all4_pending", 8'(pending), 8'hf);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("all4_valid", 8'(valid), 8'h1);
            chk("all4_drop", 8'(drop), 8'h0);
        end
        drain("all4");

        // Backpressure: code held while ready=0.
        do_reset();
        en = 1'b1;
        ready = 1'b0;
        d = 4'b0011;
`ifdef ENCODER42_ROUND_ROBIN_EN
        q.push_back(2'd0); q.push_back(2'd1);
`else
        q.push_back(2'd1); q.push_back(2'd0);
`endif
        tick();
        d = 4'b0000;
        tick();
        for (int i = 0; i < 5; i++) begin
`ifdef ENCODER42_ROUND_ROBIN_EN
            chk("bp_hold_y", 8'(y), 8'h0);
            chk("bp_hold_pending", 8'(pending), 8'h2);
`else
            chk("bp_hold_y", 8'(y), 8'h1);
            chk("bp_hold_pending", 8'(pending), 8'h1);
`endif
            chk("bp_hold_valid", 8'(valid), 8'h1);
            tick();
        end
        ready = 1'b1;
        tick();
        chk("bp_second_valid", 8'(valid), 8'h1);
`ifdef ENCODER42_ROUND_ROBIN_EN
        chk("bp_second_y", 8'(y), 8'h1);
`else
        chk("bp_second_y", 8'(y), 8'h0);
`endif
        tick();
        chk("bp_empty_valid", 8'(valid), 8'h0);

        // Merge: duplicate request on a pending bit flags drop, one code.
        do_reset();
        en = 1'b1;
        ready = 1'b0;
        d = 4'b0001;
        tick();
        d = 4'b0000;
        tick();
        d = 4'b0010;
        tick();
        chk("merge_pending", 8'(pending), 8'h2);
        chk("merge_drop0", 8'(drop), 8'h0);
        tick();
        d = 4'b0000;
        chk("merge_drop1", 8'(drop), 8'h1);
        chk("merge_pending2", 8'(pending), 8'h2);
        tick();
        chk("merge_drop_end", 8'(drop), 8'h0);
        q.push_back(2'd0);
        q.push_back(2'd1);
        ready = 1'b1;
        drain("merge");

        // Set wins over clear in the grant cycle.
        do_reset();
        en = 1'b1;
        ready = 1'b1;
        d = 4'b1000;
        q.push_back(2'd3);
        q.push_back(2'd3);
        tick();
        chk("setwin_pending1", 8'(pending), 8'h8);
        tick();
        d = 4'b0000;
        chk("setwin_y", 8'(y), 8'h3);
        chk("setwin_valid", 8'(valid), 8'h1);
        chk("setwin_pending", 8'(pending), 8'h8);
        chk("setwin_drop", 8'(drop), 8'h0);
        drain("setwin");

        // Persistent requests on bits 0 and 3, then en=0 drains.
        do_reset();
        en = 1'b1;
        ready = 1'b1;
        d = 4'b1001;
`ifdef ENCODER42_ROUND_ROBIN_EN
        for (int i = 0; i < 7; i++)
            q.push_back((i % 2 == 0) ? 2'd0 : 2'd3);
`else
        for (int i = 0; i < 6; i++)
            q.push_back(2'd3);
        q.push_back(2'd0);
`endif
        repeat (6) tick();
        en = 1'b0;
        d = 4'b0000;
        drain("persist");

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
